// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and load/store traffic
module mem_arbiter #(
    parameter int ADDR_W          = 6,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              data_req,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       fetch_grants,
    output logic [15:0]       data_grants
);
    typedef enum logic [1:0] {IDLE, FETCH_WAIT, DATA_WAIT} state_t;
    state_t     state;
    logic [3:0] streak;
    logic       store_q;
    logic       idle;
    logic       grant_data;
    logic       grant_fetch;
    assign idle        = state == IDLE && !reset;
    assign grant_data  = idle && data_req && !(fetch_req && streak == 4'(MAX_DATA_STREAK));
    assign grant_fetch = idle && fetch_req && !grant_data;
    // memory request from the winner and response steering; reset suppresses grants and valid pulses
    always_comb begin
        mem_en      = grant_data || grant_fetch;
        mem_we      = grant_data && data_write;
        mem_addr    = grant_data ? data_addr : grant_fetch ? fetch_addr : '0;
        mem_wdata   = mem_we ? data_wdata : '0;
        fetch_valid = state == FETCH_WAIT && !reset;
        data_valid  = state == DATA_WAIT && !reset;
        fetch_data  = fetch_valid ? mem_rdata : '0;
        data_rdata  = data_valid && !store_q ? mem_rdata : '0;
        stall       = (fetch_req && !fetch_valid) || (data_req && !data_valid);
    end
    // FSM, anti-starvation streak and saturating grant counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            streak       <= '0;
            store_q      <= 1'b0;
            fetch_grants <= '0;
            data_grants  <= '0;
        end else begin
            state        <= grant_data ? DATA_WAIT : grant_fetch ? FETCH_WAIT : IDLE;
            streak       <= grant_fetch ? '0 : (grant_data && fetch_req) ? streak + 4'd1 : streak;
            store_q      <= grant_data ? data_write : store_q;
            fetch_grants <= fetch_grants + 16'(grant_fetch && fetch_grants != 16'hFFFF);
            data_grants  <= data_grants + 16'(grant_data && data_grants != 16'hFFFF);
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus corner sequences, results checked through a scoreboard queue
module tb_mem_arbiter;
    typedef struct {
        logic        f;
        logic        w;
        logic [5:0]  a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    typedef struct {
        logic        f;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, data_req, data_write;
    logic [5:0]  fetch_addr, data_addr;
    logic [31:0] data_wdata;
    logic        fetch_valid, data_valid, stall, mem_en, mem_we;
    logic [31:0] fetch_data, data_rdata, mem_wdata, mem_rdata;
    logic [5:0]  mem_addr;
    logic [15:0] fetch_grants, data_grants;
    logic [31:0] mem [64];
    exp_t        sb[$];
    vec_t        vecs [10];
    int          n_vec = 0;
    int          n_err = 0;
    int          nf = 0;
    int          nd = 0;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .data_req(data_req), .data_write(data_write), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_valid(data_valid), .data_rdata(data_rdata),
        .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fetch_grants(fetch_grants), .data_grants(data_grants)
    );

    always #5 clk = ~clk;

    // single-port memory with one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // pops the scoreboard on every valid pulse
    always @(negedge clk) begin
        if (fetch_valid || data_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'({fetch_valid, data_valid}), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid_kind", 32'({fetch_valid, data_valid}), e.f ? 32'd2 : 32'd1);
                chk("resp_data", e.f ? fetch_data : data_rdata, e.d);
                chk("other_data", e.f ? data_rdata : fetch_data, 32'd0);
            end
        end
    end

    task automatic xact(input vec_t v);
        fetch_req  = v.f;
        fetch_addr = v.a;
        data_req   = !v.f;
        data_write = v.w;
        data_addr  = v.a;
        data_wdata = v.wd;
        #1;
        chk("grant_en", 32'(mem_en), 32'd1);
        chk("grant_addr", 32'(mem_addr), 32'(v.a));
        chk("grant_we", 32'(mem_we), 32'(!v.f && v.w));
        chk("grant_wdata", mem_wdata, (!v.f && v.w) ? v.wd : 32'd0);
        sb.push_back('{f: v.f, d: v.exp});
        @(posedge clk); #1;
        chk("stall_in_wait", 32'(stall), 32'd0);
        @(posedge clk); #1;
        fetch_req = 1'b0;
        data_req  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 6'h05, 32'h00500093, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 6'h05, 32'h0, 32'h00500093};
        vecs[2] = '{1'b0, 1'b1, 6'h3F, 32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 6'h3F, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b0, 6'h05, 32'h0, 32'h00500093};
        vecs[5] = '{1'b0, 1'b1, 6'h00, 32'hFFFFFFFF, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 6'h00, 32'h0, 32'hFFFFFFFF};
        vecs[7] = '{1'b1, 1'b0, 6'h3F, 32'h0, 32'hDEADBEEF};
        vecs[8] = '{1'b0, 1'b1, 6'h3F, 32'h0, 32'h0};
        vecs[9] = '{1'b0, 1'b0, 6'h3F, 32'h12345678, 32'h0};
        reset = 1'b1;
        {fetch_req, data_req, data_write} = '0;
        fetch_addr = '0;
        data_addr  = '0;
        data_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        fetch_req = 1'b1;
        data_req  = 1'b1;
        #1;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_fvalid", 32'(fetch_valid), 32'd0);
        chk("rst_dvalid", 32'(data_valid), 32'd0);
        chk("rst_fgrants", 32'(fetch_grants), 32'd0);
        chk("rst_dgrants", 32'(data_grants), 32'd0);
        fetch_req = 1'b0;
        data_req  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_mem_en", 32'(mem_en), 32'd0);
        for (int i = 0; i < 10; i++) begin
            xact(vecs[i]);
            if (vecs[i].f) nf++; else nd++;
        end
        chk("tbl_fgrants", 32'(fetch_grants), 32'(nf));
        chk("tbl_dgrants", 32'(data_grants), 32'(nd));

        // fetch and load together: load first, fetch two cycles later
        fetch_req  = 1'b1;
        fetch_addr = 6'h05;
        data_req   = 1'b1;
        data_write = 1'b0;
        data_addr  = 6'h00;
        #1;
        chk("both_first_en", 32'(mem_en), 32'd1);
        chk("both_first_addr", 32'(mem_addr), 32'd0);
        chk("both_first_we", 32'(mem_we), 32'd0);
        chk("both_stall_n", 32'(stall), 32'd1);
        sb.push_back('{f: 1'b0, d: 32'hFFFFFFFF});
        @(posedge clk); #1;
        chk("both_stall_n1", 32'(stall), 32'd1);
        chk("both_wait_en", 32'(mem_en), 32'd0);
        @(posedge clk); #1;
        data_req = 1'b0;
        #1;
        chk("both_second_en", 32'(mem_en), 32'd1);
        chk("both_second_addr", 32'(mem_addr), 32'd5);
        chk("both_stall_n2", 32'(stall), 32'd1);
        sb.push_back('{f: 1'b1, d: 32'h00500093});
        @(posedge clk); #1;
        chk("both_stall_n3", 32'(stall), 32'd0);
        @(posedge clk); #1;
        fetch_req = 1'b0;
        nf++;
        nd++;

        // starvation guard: both held, pattern D,D,D,D,F repeats
        fetch_req  = 1'b1;
        fetch_addr = 6'h05;
        data_req   = 1'b1;
        data_write = 1'b0;
        data_addr  = 6'h00;
        for (int k = 0; k < 10; k++) begin
            logic fk;
            fk = (k % 5) == 4;
            #1;
            chk("starve_en", 32'(mem_en), 32'd1);
            chk("starve_addr", 32'(mem_addr), fk ? 32'd5 : 32'd0);
            chk("starve_we", 32'(mem_we), 32'd0);
            sb.push_back('{f: fk, d: fk ? 32'h00500093 : 32'hFFFFFFFF});
            if (fk) nf++; else nd++;
            repeat (2) @(posedge clk);
        end
        #1;
        fetch_req = 1'b0;
        data_req  = 1'b0;
        chk("starve_fgrants", 32'(fetch_grants), 32'(nf));
        chk("starve_dgrants", 32'(data_grants), 32'(nd));

        // reset while a load is outstanding: no pulse, counters cleared, regrant on release
        data_req   = 1'b1;
        data_write = 1'b0;
        data_addr  = 6'h00;
        #1;
        chk("abort_grant", 32'(mem_en), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_no_valid", 32'(data_valid), 32'd0);
        @(posedge clk); #1;
        chk("abort_fgrants", 32'(fetch_grants), 32'd0);
        chk("abort_dgrants", 32'(data_grants), 32'd0);
        chk("abort_rst_en", 32'(mem_en), 32'd0);
        chk("abort_rst_valid", 32'(data_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("regrant_en", 32'(mem_en), 32'd1);
        chk("regrant_addr", 32'(mem_addr), 32'd0);
        sb.push_back('{f: 1'b0, d: 32'hFFFFFFFF});
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_req = 1'b0;
        chk("regrant_dgrants", 32'(data_grants), 32'd1);

        // counter saturation, preloaded near the top
        force dut.fetch_grants = 16'hFFFD;
        #1;
        release dut.fetch_grants;
        #1;
        chk("sat_preload", 32'(fetch_grants), 32'h0000FFFD);
        xact(vecs[1]);
        chk("sat_fffe", 32'(fetch_grants), 32'h0000FFFE);
        xact(vecs[1]);
        chk("sat_ffff", 32'(fetch_grants), 32'h0000FFFF);
        xact(vecs[1]);
        chk("sat_hold", 32'(fetch_grants), 32'h0000FFFF);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, word address width, matching the instruction/data memory address width.
REQ-002 Parameter DATA_W, default 32, memory word width.
REQ-003 Parameter MAX_DATA_STREAK, default 4, maximum consecutive data grants while a fetch is pending; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 fetch_req  in  1  instruction fetch request; held with stable fetch_addr until fetch_valid.
REQ-007 fetch_addr  in  ADDR_W  fetch word address (PC).
REQ-008 fetch_valid  out  1  one-cycle pulse: fetch_data holds the fetched word.
REQ-009 fetch_data  out  DATA_W  fetched instruction.
REQ-010 data_req  in  1  load/store request; held with stable data_addr, data_write, data_wdata until data_valid.
REQ-011 data_write  in  1  1 = store, 0 = load.
REQ-012 data_addr  in  ADDR_W  data word address (ALU result).
REQ-013 data_wdata  in  DATA_W  store data.
REQ-014 data_valid  out  1  one-cycle pulse: load data returned or store committed.
REQ-015 data_rdata  out  DATA_W  load result; 0 on store completion.
REQ-016 stall  out  1  combinational: (fetch_req & ~fetch_valid) | (data_req & ~data_valid).
REQ-017 mem_en, mem_we  out  1 each  single-port memory enable and write enable.
REQ-018 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W  (read data valid exactly one cycle after mem_en).
REQ-019 fetch_grants, data_grants  out  16 each  saturating grant counters.

Function
REQ-020 FSM states IDLE, FETCH_WAIT, DATA_WAIT; at most one memory transaction outstanding.
REQ-021 IDLE: on a grant, drive mem_en=1 and mem_addr/mem_we/mem_wdata from the winner in that same cycle (combinational), then go to the corresponding WAIT state.
REQ-022 Arbitration in IDLE: data wins over fetch unless fetch_req=1 and streak counter = MAX_DATA_STREAK, in which case fetch wins.
REQ-023 Streak counter: +1 on each data grant while fetch_req=1; cleared on every fetch grant; held when fetch_req=0 at data grant.
REQ-024 Fetch grants always use mem_we=0, mem_wdata=0.
REQ-025 FETCH_WAIT: fetch_valid=1, fetch_data=mem_rdata, mem_en=0; next state IDLE unconditionally.
REQ-026 DATA_WAIT: data_valid=1, data_rdata=mem_rdata for loads and 0 for stores, mem_en=0; next state IDLE.
REQ-027 No grant is issued in a WAIT state; earliest next grant is the cycle after a valid pulse (max one transaction per 2 cycles).
REQ-028 Outputs not active in the current state are 0: fetch_data/data_rdata are 0 when their valid is 0; mem_addr/mem_wdata are 0 when mem_en=0.
REQ-029 Grant counters increment on each grant in IDLE; hold at 16'hFFFF.
REQ-030 A request deasserted before its valid pulse is protocol violation; behaviour unspecified, no assertion required.

Reset
REQ-031 While reset=1 (sampled at clk edge): state IDLE, streak counter 0, fetch_grants=data_grants=0.
REQ-032 During and after reset, fetch_valid, data_valid, mem_en, mem_we are 0 in the cycle following the reset edge; no grant is issued while reset=1.
REQ-033 Reset during a WAIT state aborts the transaction; no valid pulse is generated for it.

Verification
REQ-034 Fetch only: fetch_req=1, fetch_addr=0x05, mem_rdata=0x00500093 next cycle -> mem_en=1, mem_addr=5 cycle N; fetch_valid=1, fetch_data=0x00500093 cycle N+1; fetch_grants=1.
REQ-035 Store: data_req=1, data_write=1, data_addr=0x3F, data_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x3F, mem_wdata=0xDEADBEEF cycle N; data_valid=1, data_rdata=0 cycle N+1.
REQ-036 Simultaneous fetch and load from IDLE -> data granted first (DATA_WAIT), fetch granted at N+2, fetch_valid at N+3; stall=1 cycles N..N+2, 0 at N+3 only if no requests remain.
REQ-037 Starvation: MAX_DATA_STREAK=4, fetch_req held, data_req held continuously -> grants D,D,D,D,F,D... observed on mem_we/mem_addr sequence.
REQ-038 Reset asserted in DATA_WAIT -> no data_valid pulse, state IDLE, counters 0; after release, a held data_req is granted in the first non-reset cycle.
REQ-039 Counter saturation: force 65537 fetch grants -> fetch_grants stays 0xFFFF.
